// File: rtl/uart_cmd_sched.sv
// Command scheduler: decodes UART bytes and button pulses, runs the STOP/RUN/CLEAR
// FSM, owns the stopwatch/clock mode bit and returns an ACK/NAK byte to the UART TX.
module uart_cmd_sched #(
    parameter logic       ACK_EN   = 1'b1,
    parameter logic [7:0] NAK_CHAR = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic       btn_hour,
    input  logic       tx_busy,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       o_sec,
    output logic       o_min,
    output logic       o_hour,
    output logic       mode,
    output logic       tx_start,
    output logic [7:0] tx_data
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_RUN   = 3'd1;
    localparam logic [2:0] CMD_CLEAR = 3'd2;
    localparam logic [2:0] CMD_SEC   = 3'd3;
    localparam logic [2:0] CMD_MIN   = 3'd4;
    localparam logic [2:0] CMD_HOUR  = 3'd5;
    localparam logic [2:0] CMD_MODE  = 3'd6;

    function automatic logic [2:0] decode_cmd(input logic [7:0] b);
        logic [7:0] u;
        u = (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
        case (u)
            8'h52:   decode_cmd = CMD_RUN;
            8'h43:   decode_cmd = CMD_CLEAR;
            8'h53:   decode_cmd = CMD_SEC;
            8'h4D:   decode_cmd = CMD_MIN;
            8'h48:   decode_cmd = CMD_HOUR;
            8'h49:   decode_cmd = CMD_MODE;
            default: decode_cmd = CMD_NONE;
        endcase
    endfunction

    function automatic logic [7:0] ack_byte(input logic [7:0] b);
        ack_byte = (decode_cmd(b) != CMD_NONE) ? b : NAK_CHAR;
    endfunction

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       mode_r;
    logic       q_vld_p1;
    logic [2:0] q_cmd_p1;
    logic       pend_vld_p1;
    logic [7:0] pend_byte_p1;

    logic [2:0] rx_cmd;
    logic       rx_cmd_vld;
    logic       btn_any;
    logic [2:0] sel_cmd;
    logic       c_run, c_clear, c_sec, c_min, c_hour, c_mode;
    logic       live;
    logic       tx_go;
    logic [7:0] tx_cand;

    // Buttons own the cycle; a colliding UART command waits one cycle in the queue.
    always_comb begin
        rx_cmd     = decode_cmd(rx_data);
        rx_cmd_vld = rx_done && (rx_cmd != CMD_NONE);
        btn_any    = btn_run | btn_clear | btn_sec | btn_min | btn_hour;
        sel_cmd    = CMD_NONE;
        c_run      = 1'b0;
        c_clear    = 1'b0;
        c_sec      = 1'b0;
        c_min      = 1'b0;
        c_hour     = 1'b0;
        c_mode     = 1'b0;
        if (btn_any) begin
            c_run   = btn_run;
            c_clear = btn_clear & ~btn_run;
            c_sec   = btn_sec;
            c_min   = btn_min;
            c_hour  = btn_hour;
        end else begin
            sel_cmd = rx_cmd_vld ? rx_cmd : (q_vld_p1 ? q_cmd_p1 : CMD_NONE);
            c_run   = (sel_cmd == CMD_RUN);
            c_clear = (sel_cmd == CMD_CLEAR);
            c_sec   = (sel_cmd == CMD_SEC);
            c_min   = (sel_cmd == CMD_MIN);
            c_hour  = (sel_cmd == CMD_HOUR);
            c_mode  = (sel_cmd == CMD_MODE);
        end
        live    = (state == ST_STOP) || (state == ST_RUN);
        tx_cand = rx_done ? ack_byte(rx_data) : pend_byte_p1;
        tx_go   = ACK_EN && (rx_done || pend_vld_p1) && !tx_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_STOP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_STOP;
        case (state)
            ST_STOP: begin
                if (c_mode)                state_nxt = ST_STOP;
                else if (!mode_r && c_run)   state_nxt = ST_RUN;
                else if (!mode_r && c_clear) state_nxt = ST_CLEAR;
                else                         state_nxt = ST_STOP;
            end
            ST_RUN: begin
                if (c_mode || (!mode_r && c_run)) state_nxt = ST_STOP;
                else                              state_nxt = ST_RUN;
            end
            default: state_nxt = ST_STOP;
        endcase
    end

    always_comb begin
        sw_run   = (state == ST_RUN);
        sw_clear = (state == ST_CLEAR);
        mode     = mode_r;
    end

    // p1 stage: mode, command queue, increment pulses and the ACK/NAK return path
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r       <= 1'b0;
            q_vld_p1     <= 1'b0;
            q_cmd_p1     <= CMD_NONE;
            pend_vld_p1  <= 1'b0;
            pend_byte_p1 <= 8'h00;
            o_sec        <= 1'b0;
            o_min        <= 1'b0;
            o_hour       <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
        end else begin
            o_sec  <= live && mode_r && c_sec;
            o_min  <= live && mode_r && c_min;
            o_hour <= live && mode_r && c_hour;
            if (live && c_mode) mode_r <= ~mode_r;

            if (btn_any) begin
                if (rx_cmd_vld) begin
                    q_vld_p1 <= 1'b1;
                    q_cmd_p1 <= rx_cmd;
                end
            end else begin
                q_vld_p1 <= 1'b0;
            end

            if (tx_go) begin
                tx_start    <= 1'b1;
                tx_data     <= tx_cand;
                pend_vld_p1 <= 1'b0;
            end else begin
                tx_start <= 1'b0;
                if (rx_done) begin
                    pend_vld_p1  <= 1'b1;
                    pend_byte_p1 <= tx_cand;
                end
            end
        end
    end

endmodule
